// File: rtl/vote_collector.sv
// Three-key vote collector: synchronized, debounced push-buttons feed
// registered vote bits for a downstream majority voter during a timed window.
module vote_collector #(
   parameter int DEB_CYCLES    = 4,
   parameter int WINDOW_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic key_a,
   input  logic key_b,
   input  logic key_c,
   input  logic start,
   output logic A,
   output logic B,
   output logic C,
   output logic busy,
   output logic done
);

   typedef enum logic [1:0] {
      IDLE,
      VOTE,
      DONE
   } state_t;

   localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES - 1);
   localparam logic [7:0] WIN_LOAD = 8'(WINDOW_CYCLES - 1);

   logic [2:0] keys;
   logic [2:0] s1;
   logic [2:0] s2;
   logic [2:0] stable;
   logic [2:0] rise;
   logic [3:0] cnt [3];

   state_t     state_q;
   state_t     state_d;
   logic [2:0] votes_q;
   logic [2:0] votes_d;
   logic [7:0] timer_q;
   logic [7:0] timer_d;

   assign keys = {key_c, key_b, key_a};

   // Two-flop synchronizer for the raw button levels
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= keys;
         s2 <= s1;
      end
   end

   // Per-key debouncer: a new level must persist DEB_CYCLES samples
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stable <= '0;
         for (int i = 0; i < 3; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (s2[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == DEB_LAST) begin
               stable[i] <= s2[i];
               cnt[i]    <= '0;
            end else begin
               cnt[i] <= cnt[i] + 4'd1;
            end
         end
      end
   end

   // A rise is the edge on which stable is about to go 0->1, so the
   // vote can be captured on that very same edge.
   always_comb begin
      rise = '0;
      for (int i = 0; i < 3; i++)
         rise[i] = ~stable[i] & s2[i] & (cnt[i] == DEB_LAST);
   end

   // Round control state, vote bits and window timer registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         votes_q <= '0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         votes_q <= votes_d;
         timer_q <= timer_d;
      end
   end

   // Next-state logic: open on start, collect rises, close on timeout or full vote
   always_comb begin
      state_d = state_q;
      votes_d = votes_q;
      timer_d = timer_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = VOTE;
               votes_d = '0;
               timer_d = WIN_LOAD;
            end
         end
         VOTE: begin
            votes_d = votes_q | rise;
            if (timer_q != 8'd0) timer_d = timer_q - 8'd1;
            if (timer_q == 8'd0 || &(votes_q | rise)) state_d = DONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign A    = votes_q[0];
   assign B    = votes_q[1];
   assign C    = votes_q[2];
   assign busy = (state_q == VOTE);
   assign done = (state_q == DONE);

endmodule
